// File: rtl/debounce_filt.sv
// Multi-channel debounce/glitch filter: optional input synchroniser followed by
// an independent hysteresis FSM per channel with separate rise/fall thresholds.
module debounce_filt #(
   parameter int             W       = 4,
   parameter int             RISE_TH = 10,
   parameter int             FALL_TH = 10,
   parameter int             SYNC    = 2,
   parameter logic [W-1:0]   INIT    = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] i,
   output logic [W-1:0] y,
   output logic [W-1:0] rise,
   output logic [W-1:0] fall,
   output logic [W-1:0] busy
);

   // state | meaning
   // LO    | y=0, input agrees with output
   // RISE  | y=0, qualifying a run of high samples
   // HI    | y=1, input agrees with output
   // FALL  | y=1, qualifying a run of low samples
   typedef enum logic [1:0] {
      ST_LO   = 2'd0,
      ST_RISE = 2'd1,
      ST_HI   = 2'd2,
      ST_FALL = 2'd3
   } st_t;

   localparam int MAXTH = (RISE_TH > FALL_TH) ? RISE_TH : FALL_TH;
   localparam int CW    = $clog2(MAXTH + 1);

   logic [W-1:0] i_s;

   if (SYNC == 0) begin : g_nosync
      assign i_s = i;
   end else begin : g_sync
      logic [W-1:0] sq [SYNC];

      // Synchroniser keeps running while en=0 so the FSM sees fresh data on resume.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int j = 0; j < SYNC; j++) sq[j] <= INIT;
         end else begin
            sq[0] <= i;
            for (int j = 1; j < SYNC; j++) sq[j] <= sq[j-1];
         end
      end

      assign i_s = sq[SYNC-1];
   end

   for (genvar k = 0; k < W; k++) begin : g_ch
      st_t           state;
      logic [CW-1:0] cnt;
      logic          y_r;
      logic          rise_r;
      logic          fall_r;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state  <= INIT[k] ? ST_HI : ST_LO;
            cnt    <= '0;
            y_r    <= INIT[k];
            rise_r <= 1'b0;
            fall_r <= 1'b0;
         end else if (en) begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            case (state)
               ST_LO: begin
                  if (i_s[k]) begin
                     state <= ST_RISE;
                     cnt   <= CW'(1);
                  end else begin
                     cnt   <= '0;
                  end
               end
               ST_RISE: begin
                  // A contrary sample aborts even when the count is complete.
                  if (!i_s[k]) begin
                     state <= ST_LO;
                     cnt   <= '0;
                  end else if (cnt == CW'(RISE_TH - 1)) begin
                     state  <= ST_HI;
                     y_r    <= 1'b1;
                     rise_r <= 1'b1;
                     cnt    <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               ST_HI: begin
                  if (!i_s[k]) begin
                     state <= ST_FALL;
                     cnt   <= CW'(1);
                  end else begin
                     cnt   <= '0;
                  end
               end
               ST_FALL: begin
                  if (i_s[k]) begin
                     state <= ST_HI;
                     cnt   <= '0;
                  end else if (cnt == CW'(FALL_TH - 1)) begin
                     state  <= ST_LO;
                     y_r    <= 1'b0;
                     fall_r <= 1'b1;
                     cnt    <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               default: begin
                  state <= ST_LO;
                  cnt   <= '0;
               end
            endcase
         end else begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
         end
      end

      assign y[k]    = y_r;
      assign rise[k] = rise_r;
      assign fall[k] = fall_r;
      assign busy[k] = (state == ST_RISE) || (state == ST_FALL);
   end

endmodule

// File: tb/tb_debounce_filt.sv
// Scoreboard bench for debounce_filt: four differently configured instances share
// one stimulus stream and are checked against a run-length reference model.
module tb_debounce_filt;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [3:0] i = 4'b0000;

   logic [3:0] yo [4];
   logic [3:0] ro [4];
   logic [3:0] fo [4];
   logic [3:0] bo [4];

   int tests = 0;
   int failed = 0;
   int edge_n = 0;

   always #5 clk = ~clk;

   debounce_filt #(.W(4), .RISE_TH(4), .FALL_TH(6), .SYNC(2), .INIT(4'b0000)) d0 (
      .clk(clk), .rst_n(rst_n), .en(en), .i(i),
      .y(yo[0]), .rise(ro[0]), .fall(fo[0]), .busy(bo[0]));
   debounce_filt #(.W(4), .RISE_TH(4), .FALL_TH(6), .SYNC(2), .INIT(4'b1010)) d1 (
      .clk(clk), .rst_n(rst_n), .en(en), .i(i),
      .y(yo[1]), .rise(ro[1]), .fall(fo[1]), .busy(bo[1]));
   debounce_filt #(.W(4), .RISE_TH(2), .FALL_TH(3), .SYNC(0), .INIT(4'b0000)) d2 (
      .clk(clk), .rst_n(rst_n), .en(en), .i(i),
      .y(yo[2]), .rise(ro[2]), .fall(fo[2]), .busy(bo[2]));
   debounce_filt #(.W(4), .RISE_TH(2), .FALL_TH(3), .SYNC(3), .INIT(4'b0000)) d3 (
      .clk(clk), .rst_n(rst_n), .en(en), .i(i),
      .y(yo[3]), .rise(ro[3]), .fall(fo[3]), .busy(bo[3]));

   function automatic int cfg_rth(int d);  return (d < 2) ? 4 : 2; endfunction
   function automatic int cfg_fth(int d);  return (d < 2) ? 6 : 3; endfunction
   function automatic int cfg_sync(int d); return (d < 2) ? 2 : ((d == 2) ? 0 : 3); endfunction
   function automatic logic [3:0] cfg_init(int d); return (d == 1) ? 4'b1010 : 4'b0000; endfunction

   typedef struct {
      int         d;
      int         e;
      logic [3:0] y;
      logic [3:0] r;
      logic [3:0] f;
      logic [3:0] b;
   } exp_t;

   exp_t q[$];

   // Reference: y flips once the input has disagreed with it for TH consecutive
   // enabled samples; the synchroniser is a plain delay line of past inputs.
   logic [3:0] m_y [4];
   int         m_run [4][4];
   logic [3:0] m_hist [4][3];
   logic [3:0] m_is, m_r, m_f, m_b;
   exp_t       m_e;

   initial begin
      forever begin
         @(posedge clk);
         edge_n++;
         for (int d = 0; d < 4; d++) begin
            m_r = 4'b0000;
            m_f = 4'b0000;
            if (!rst_n) begin
               m_y[d] = cfg_init(d);
               for (int k = 0; k < 4; k++) m_run[d][k] = 0;
               for (int j = 0; j < 3; j++) m_hist[d][j] = cfg_init(d);
            end else begin
               m_is = (cfg_sync(d) == 0) ? i : m_hist[d][cfg_sync(d)-1];
               for (int j = 2; j > 0; j--) m_hist[d][j] = m_hist[d][j-1];
               m_hist[d][0] = i;
               if (en) begin
                  for (int k = 0; k < 4; k++) begin
                     if (m_is[k] != m_y[d][k]) begin
                        m_run[d][k]++;
                        if (m_run[d][k] == (m_y[d][k] ? cfg_fth(d) : cfg_rth(d))) begin
                           if (m_y[d][k]) m_f[k] = 1'b1;
                           else           m_r[k] = 1'b1;
                           m_y[d][k]  = ~m_y[d][k];
                           m_run[d][k] = 0;
                        end
                     end else begin
                        m_run[d][k] = 0;
                     end
                  end
               end
            end
            for (int k = 0; k < 4; k++) m_b[k] = (m_run[d][k] > 0);
            m_e.d = d;
            m_e.e = edge_n;
            m_e.y = m_y[d];
            m_e.r = m_r;
            m_e.f = m_f;
            m_e.b = m_b;
            q.push_back(m_e);
         end
      end
   end

   task automatic chk(input string nm, input int d, input int e,
                      input logic [3:0] act, input logic [3:0] want);
      tests++;
      if (act !== want) begin
         failed++;
         $display("FAIL %s dut%0d edge %0d: got %b expected %b", nm, d, e, act, want);
      end
   endtask

   exp_t c;
   initial begin
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            c = q.pop_front();
            chk("y",    c.d, c.e, yo[c.d], c.y);
            chk("rise", c.d, c.e, ro[c.d], c.r);
            chk("fall", c.d, c.e, fo[c.d], c.f);
            chk("busy", c.d, c.e, bo[c.d], c.b);
            tests++;
            if ((ro[c.d] & fo[c.d]) != 4'b0000) begin
               failed++;
               $display("FAIL rise_and_fall dut%0d edge %0d: got %b expected 0000",
                        c.d, c.e, ro[c.d] & fo[c.d]);
            end
         end
      end
   end

   // Values set here are sampled at the next rising edge.
   task automatic cyc(input logic r, input logic e, input logic [3:0] v);
      @(posedge clk);
      #2;
      rst_n = r;
      en    = e;
      i     = v;
   endtask

   int         got [4];
   int         e0;
   logic [3:0] lvl;
   int         hold [4];

   initial begin
      #100_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) cyc(1'b0, 1'b1, 4'b0000);
      repeat (8) cyc(1'b1, 1'b1, 4'b0000);

      // Single rise on ch0: latency = SYNC + RISE_TH - 1 edges after the first sample.
      cyc(1'b1, 1'b1, 4'b0001);
      e0 = edge_n + 1;
      for (int d = 0; d < 4; d++) got[d] = -1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         for (int d = 0; d < 4; d++)
            if (ro[d][0] && got[d] < 0) got[d] = edge_n;
      end
      chk("lat_sync2_th4", 0, e0, 4'(got[0] - e0), 4'd5);
      chk("lat_sync0_th2", 2, e0, 4'(got[2] - e0), 4'd1);
      chk("lat_sync3_th2", 3, e0, 4'(got[3] - e0), 4'd4);
      repeat (2) cyc(1'b1, 1'b1, 4'b0001);
      repeat (12) cyc(1'b1, 1'b1, 4'b0000);

      // ch1: short glitch, exact-threshold pulse, short low dip.
      repeat (3) cyc(1'b1, 1'b1, 4'b0010);
      repeat (5) cyc(1'b1, 1'b1, 4'b0000);
      repeat (4) cyc(1'b1, 1'b1, 4'b0010);
      repeat (5) cyc(1'b1, 1'b1, 4'b0000);
      repeat (10) cyc(1'b1, 1'b1, 4'b0010);
      repeat (12) cyc(1'b1, 1'b1, 4'b0000);

      // All channels rise together with different glitch patterns.
      cyc(1'b1, 1'b1, 4'b1111);
      cyc(1'b1, 1'b1, 4'b1101);
      cyc(1'b1, 1'b1, 4'b1111);
      cyc(1'b1, 1'b1, 4'b0111);
      cyc(1'b1, 1'b1, 4'b1111);
      cyc(1'b1, 1'b1, 4'b1011);
      repeat (10) cyc(1'b1, 1'b1, 4'b1111);
      repeat (12) cyc(1'b1, 1'b1, 4'b0000);

      // en toggling during a rise on ch2.
      repeat (3) cyc(1'b1, 1'b1, 4'b0100);
      for (int n = 0; n < 10; n++) cyc(1'b1, n[0], 4'b0100);
      repeat (4) cyc(1'b1, 1'b1, 4'b0100);
      repeat (3) cyc(1'b1, 1'b1, 4'b0000);
      for (int n = 0; n < 12; n++) cyc(1'b1, n[0], 4'b0000);

      // Reset mid-qualification, then requalify.
      repeat (4) cyc(1'b1, 1'b1, 4'b1111);
      cyc(1'b0, 1'b1, 4'b1111);
      repeat (12) cyc(1'b1, 1'b1, 4'b1111);
      repeat (4) cyc(1'b1, 1'b1, 4'b0101);
      cyc(1'b0, 1'b0, 4'b0101);
      repeat (12) cyc(1'b1, 1'b1, 4'b0101);

      // Randomised holds of varying length, occasional en=0 and rare resets.
      for (int k = 0; k < 4; k++) hold[k] = 0;
      lvl = 4'b0000;
      for (int n = 0; n < 3000; n++) begin
         for (int k = 0; k < 4; k++) begin
            if (hold[k] == 0) begin
               lvl[k]  = 1'($urandom_range(0, 1));
               hold[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                      : int'($urandom_range(4, 12));
            end
            hold[k]--;
         end
         cyc(($urandom_range(0, 499) != 0), ($urandom_range(0, 7) != 0), lvl);
      end

      repeat (4) cyc(1'b1, 1'b1, 4'b0000);
      for (int n = 0; n < 10 && q.size() > 0; n++) @(negedge clk);
      @(negedge clk);
      #1;
      tests++;
      if (q.size() != 0) begin
         failed++;
         $display("FAIL drain: got %0d pending entries expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
